// File: rtl/zigzag_rle_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | zigzag_rle_encoder: zigzag-ordered coefficients -> JPEG DC/AC/ZRL/EOB      |
// | symbols. Optional DC DPCM predictor enabled by macro RLE_DC_DPCM_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module zigzag_rle_encoder #(
  parameter int DATA_WIDTH = 10,
  parameter int AMP_WIDTH  = DATA_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_dc,
  output logic                         out_eob,
  output logic [3:0]                   out_run,
  output logic [3:0]                   out_size,
  output logic [AMP_WIDTH-1:0]         out_amp,
  output logic                         done
);

  localparam logic [1:0] c_ST_ACCEPT = 2'd0;
  localparam logic [1:0] c_ST_ZRL    = 2'd1;
  localparam logic [1:0] c_ST_SYM    = 2'd2;
  localparam logic [1:0] c_ST_EOB    = 2'd3;

  function automatic logic [3:0] f_size(input logic [AMP_WIDTH-1:0] mag);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < AMP_WIDTH; i++)
      if (mag[i]) s = 4'(i + 1);
    return s;
  endfunction

  logic [1:0]                  r_state, w_state_nxt;
  logic [5:0]                  r_idx, r_run;
  logic [1:0]                  r_zrl_cnt;
  logic signed [DATA_WIDTH-1:0] r_hold;
  logic                        r_hold_last;
  logic                        r_out_valid, r_out_dc, r_out_eob, r_out_last;
  logic [3:0]                  r_out_run, r_out_size;
  logic [AMP_WIDTH-1:0]        r_out_amp;

  logic                        w_in_ready, w_in_fire, w_out_free;
  logic                        w_is_dc, w_is_last, w_ac_nz, w_long_run;
  logic signed [AMP_WIDTH-1:0] w_in_ext, w_dc_val, w_src_val;
  logic [AMP_WIDTH-1:0]        w_mag, w_mask, w_amp;
  logic [3:0]                  w_size;
  logic                        w_load, w_ld_dc, w_ld_eob, w_ld_last;
  logic [3:0]                  w_ld_run, w_ld_size;
  logic [AMP_WIDTH-1:0]        w_ld_amp;

  assign w_out_free = !r_out_valid || out_ready;
  assign w_is_dc    = (r_idx == 6'd0);
  assign w_is_last  = (r_idx == 6'd63);
  assign w_ac_nz    = (in_data != '0);
  assign w_long_run = (r_run[5:4] != 2'b00);
  assign w_in_ext   = AMP_WIDTH'(in_data);

  // The final symbol of a block blocks intake so the next DC follows done.
  assign w_in_ready = !rst && (r_state == c_ST_ACCEPT)
                      && (!r_out_valid || (out_ready && !r_out_last));
  assign w_in_fire  = in_valid && w_in_ready;

`ifdef RLE_DC_DPCM_EN
  logic signed [DATA_WIDTH-1:0] r_pred;
  always_ff @(posedge clk) begin
    if (rst)                        r_pred <= '0;
    else if (w_in_fire && w_is_dc)  r_pred <= in_data;
  end
  assign w_dc_val = w_in_ext - AMP_WIDTH'(r_pred);
`else
  assign w_dc_val = w_in_ext;
`endif

  // Size/amplitude share one datapath: live coefficient or the held one in SYM.
  assign w_src_val = (r_state == c_ST_SYM) ? AMP_WIDTH'(r_hold)
                   : (w_is_dc ? w_dc_val : w_in_ext);
  assign w_mag  = w_src_val[AMP_WIDTH-1] ? AMP_WIDTH'(-w_src_val) : AMP_WIDTH'(w_src_val);
  assign w_size = f_size(w_mag);
  assign w_mask = ~({AMP_WIDTH{1'b1}} << w_size);
  assign w_amp  = w_src_val[AMP_WIDTH-1] ? ((w_src_val - AMP_WIDTH'(1)) & w_mask)
                                         : w_src_val;

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_ST_ACCEPT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_ACCEPT:
        if (w_in_fire && !w_is_dc) begin
          if (w_ac_nz && w_long_run)       w_state_nxt = c_ST_ZRL;
          else if (!w_ac_nz && w_is_last)  w_state_nxt = c_ST_EOB;
        end
      c_ST_ZRL:  if (w_out_free && r_zrl_cnt == 2'd1) w_state_nxt = c_ST_SYM;
      c_ST_SYM:  if (w_out_free) w_state_nxt = c_ST_ACCEPT;
      c_ST_EOB:  if (w_out_free) w_state_nxt = c_ST_ACCEPT;
      default:   w_state_nxt = c_ST_ACCEPT;
    endcase
  end

  always_comb begin
    w_load    = 1'b0;
    w_ld_dc   = 1'b0;
    w_ld_eob  = 1'b0;
    w_ld_last = 1'b0;
    w_ld_run  = 4'd0;
    w_ld_size = 4'd0;
    w_ld_amp  = '0;
    case (r_state)
      c_ST_ACCEPT: begin
        w_load    = w_in_fire && (w_is_dc || (w_ac_nz && !w_long_run));
        w_ld_dc   = w_is_dc;
        w_ld_run  = w_is_dc ? 4'd0 : r_run[3:0];
        w_ld_size = w_size;
        w_ld_amp  = w_amp;
        w_ld_last = w_is_last;
      end
      c_ST_ZRL: begin
        w_load   = w_out_free;
        w_ld_run = 4'd15;
      end
      c_ST_SYM: begin
        w_load    = w_out_free;
        w_ld_run  = r_run[3:0];
        w_ld_size = w_size;
        w_ld_amp  = w_amp;
        w_ld_last = r_hold_last;
      end
      default: begin
        w_load    = w_out_free;
        w_ld_eob  = 1'b1;
        w_ld_last = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_run       <= '0;
      r_zrl_cnt   <= '0;
      r_hold      <= '0;
      r_hold_last <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_idx <= r_idx + 6'd1;
        if (w_is_dc)                 r_run <= '0;
        else if (!w_ac_nz)           r_run <= w_is_last ? 6'd0 : r_run + 6'd1;
        else if (!w_long_run)        r_run <= '0;
        if (!w_is_dc && w_ac_nz && w_long_run) begin
          r_zrl_cnt   <= r_run[5:4];
          r_hold      <= in_data;
          r_hold_last <= w_is_last;
        end
      end
      if (r_state == c_ST_ZRL && w_out_free) r_zrl_cnt <= r_zrl_cnt - 2'd1;
      if (r_state == c_ST_SYM && w_out_free) r_run <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_dc    <= 1'b0;
      r_out_eob   <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_run   <= '0;
      r_out_size  <= '0;
      r_out_amp   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_dc    <= w_ld_dc;
      r_out_eob   <= w_ld_eob;
      r_out_last  <= w_ld_last;
      r_out_run   <= w_ld_run;
      r_out_size  <= w_ld_size;
      r_out_amp   <= w_ld_amp;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_dc    = r_out_dc;
  assign out_eob   = r_out_eob;
  assign out_run   = r_out_run;
  assign out_size  = r_out_size;
  assign out_amp   = r_out_amp;
  assign done      = r_out_valid && out_ready && r_out_last;

endmodule
`default_nettype wire
